// File: rtl/mux_scan_sequencer_if.sv
// mux_scan_sequencer_if: control, select and sample signals of the scan sequencer.
// The slave modport belongs to the sequencer. The master modport belongs to its controller.
// Optional macro: MUX_SCAN_PARITY_EN adds the scan_parity signal.
interface mux_scan_sequencer_if #(
    parameter int unsigned DWELL_W = 4
);
    logic               start;
    logic               stop;
    logic               continuous;
    logic [3:0]         ch_mask;
    logic [DWELL_W-1:0] dwell;
    logic               mux_out;
    logic               s0;
    logic               s1;
    logic               busy;
    logic               sample_valid;
    logic [1:0]         sample_ch;
    logic               sample_bit;
    logic               scan_done;
`ifdef MUX_SCAN_PARITY_EN
    logic               scan_parity;

    modport master (
        output start, stop, continuous, ch_mask, dwell, mux_out,
        input  s0, s1, busy, sample_valid, sample_ch, sample_bit, scan_done, scan_parity
    );
    modport slave (
        input  start, stop, continuous, ch_mask, dwell, mux_out,
        output s0, s1, busy, sample_valid, sample_ch, sample_bit, scan_done, scan_parity
    );
`else
    modport master (
        output start, stop, continuous, ch_mask, dwell, mux_out,
        input  s0, s1, busy, sample_valid, sample_ch, sample_bit, scan_done
    );
    modport slave (
        input  start, stop, continuous, ch_mask, dwell, mux_out,
        output s0, s1, busy, sample_valid, sample_ch, sample_bit, scan_done
    );
`endif
endinterface

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: round-robin select sequencer for a 4:1 tri-state mux.
// It drives s1:s0, waits SETTLE cycles and samples mux_out.
// It then strobes the sample with its channel and dwells before moving to the next enabled channel.
// Optional macro: MUX_SCAN_PARITY_EN adds scan_parity, the XOR of the sample bits in a pass.
module mux_scan_sequencer #(
    parameter int unsigned DWELL_W = 4,
    parameter int unsigned SETTLE  = 2
) (
    input logic                 clk,
    input logic                 rst,
    mux_scan_sequencer_if.slave bus
);
    localparam int unsigned CntW = (DWELL_W > 4) ? DWELL_W : 4;

    typedef enum logic [1:0] {StIdle, StSettle, StDwell} state_e;

    state_e             state_q, state_d;
    logic [1:0]         ch_q, ch_d;
    logic [3:0]         mask_q, mask_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               cont_q, cont_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;
    logic               bit_q, bit_d;
    logic [1:0]         sch_q, sch_d;
    logic               par_q, par_d;
    logic               above_found;
    logic [1:0]         above_ch;
    logic [1:0]         start_ch;
    logic [1:0]         wrap_ch;

    // Lowest enabled channel of a mask (descending scan so the lowest index wins).
    function automatic logic [1:0] lowest_ch(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) r = 2'(i);
        end
        return r;
    endfunction

    // Next enabled channel strictly above the current one, if any.
    always_comb begin
        above_found = 1'b0;
        above_ch    = ch_q;
        for (int i = 3; i >= 0; i--) begin
            if (mask_q[i] && (2'(i) > ch_q)) begin
                above_found = 1'b1;
                above_ch    = 2'(i);
            end
        end
        start_ch = lowest_ch(bus.ch_mask);
        wrap_ch  = lowest_ch(mask_q);
    end

    // Next-state logic: scan sequencing, sample capture and idle clearing on stop or end of pass.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        mask_d  = mask_q;
        dwell_d = dwell_q;
        cont_d  = cont_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        bit_d   = bit_q;
        sch_d   = sch_q;
        par_d   = par_q;
        if (bus.stop) begin
            // Abort: the in-flight sample is dropped and everything returns to idle values.
            state_d = StIdle;
            ch_d    = 2'd0;
            mask_d  = 4'd0;
            dwell_d = '0;
            cont_d  = 1'b0;
            cnt_d   = '0;
            bit_d   = 1'b0;
            sch_d   = 2'd0;
            par_d   = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start && (bus.ch_mask != 4'd0)) begin
                        state_d = StSettle;
                        mask_d  = bus.ch_mask;
                        dwell_d = bus.dwell;
                        cont_d  = bus.continuous;
                        ch_d    = start_ch;
                        cnt_d   = '0;
                        par_d   = 1'b0;
                    end
                end
                StSettle: begin
                    if (cnt_q == CntW'(SETTLE - 1)) begin
                        state_d = StDwell;
                        cnt_d   = '0;
                        valid_d = 1'b1;
                        done_d  = !above_found;
                        bit_d   = bus.mux_out;
                        sch_d   = ch_q;
                        par_d   = par_q ^ bus.mux_out;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StDwell: begin
                    if (cnt_q == CntW'(dwell_q)) begin
                        cnt_d = '0;
                        if (above_found) begin
                            state_d = StSettle;
                            ch_d    = above_ch;
                        end else if (cont_q) begin
                            state_d = StSettle;
                            ch_d    = wrap_ch;
                            par_d   = 1'b0;
                        end else begin
                            state_d = StIdle;
                            ch_d    = 2'd0;
                            mask_d  = 4'd0;
                            dwell_d = '0;
                            cont_d  = 1'b0;
                            bit_d   = 1'b0;
                            sch_d   = 2'd0;
                        end
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ch_q    <= 2'd0;
            mask_q  <= 4'd0;
            dwell_q <= '0;
            cont_q  <= 1'b0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            bit_q   <= 1'b0;
            sch_q   <= 2'd0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            mask_q  <= mask_d;
            dwell_q <= dwell_d;
            cont_q  <= cont_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            bit_q   <= bit_d;
            sch_q   <= sch_d;
            par_q   <= par_d;
        end
    end

    assign bus.s0           = ch_q[0];
    assign bus.s1           = ch_q[1];
    assign bus.busy         = (state_q != StIdle);
    assign bus.sample_valid = valid_q;
    assign bus.sample_ch    = sch_q;
    assign bus.sample_bit   = bit_q;
    assign bus.scan_done    = done_q;
`ifdef MUX_SCAN_PARITY_EN
    assign bus.scan_parity  = par_q;
`else
    // The parity accumulator has no consumer without the parity port.
    logic unused_par;
    assign unused_par = par_q;
`endif
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb_mux_scan_sequencer: directed bench with a schedule-based reference model.
// The model derives the expected outputs from the start edge, the enabled channel list and the period.
module tb_mux_scan_sequencer;
    localparam int unsigned DW = 4;
    localparam int unsigned ST = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] pattern = 4'b0000;

    mux_scan_sequencer_if #(.DWELL_W(DW)) bus ();

    mux_scan_sequencer #(.DWELL_W(DW), .SETTLE(ST)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Downstream mux: each channel drives a fixed level chosen by the test.
    assign bus.mux_out = pattern[{bus.s1, bus.s0}];

    int errors = 0;
    int checks = 0;
    int edge_n = 0;

    // Reference model: a scan is fully described by its start edge and channel list.
    bit m_on   = 1'b0;
    int m_es   = 0;
    int m_n    = 1;
    int m_per  = 1;
    bit m_cont = 1'b0;
    int m_list [4];

    typedef struct {
        int e;
        int ch;
        int b;
        int d;
    } strobe_t;
    strobe_t strobes [$];
    int busy_fall = -1;
    int last_par  = -1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // The model reports busy for the cycle after edge e.
    function automatic bit running(input int e);
        return m_on && (e >= m_es) && (m_cont || (e < m_es + m_n * m_per));
    endfunction

    // Update the model from the inputs sampled on each rising edge.
    always @(posedge clk) begin : model_upd
        int e;
        int n;
        int lst [4];
        e = edge_n + 1;
        edge_n <= e;
        if (rst || bus.stop) begin
            m_on <= 1'b0;
        end else if (bus.start && (bus.ch_mask != 4'd0) && !running(e - 1)) begin
            n = 0;
            for (int i = 0; i < 4; i++) lst[i] = 0;
            for (int i = 0; i < 4; i++) begin
                if (bus.ch_mask[i]) begin
                    lst[n] = i;
                    n++;
                end
            end
            m_on   <= 1'b1;
            m_es   <= e;
            m_n    <= n;
            m_per  <= int'(ST) + 1 + int'(bus.dwell);
            m_cont <= bus.continuous;
            for (int i = 0; i < 4; i++) m_list[i] <= lst[i];
        end
    end

    // Compare the DUT against the model on every falling edge.
    always @(negedge clk) begin : compare
        int e;
        int k;
        int r;
        int ch;
        int par;
        bit run;
        bit v;
        bit d;
        bit prev_busy;
        e   = edge_n;
        ch  = 0;
        v   = 1'b0;
        d   = 1'b0;
        run = running(e);
        if (run) begin
            k  = (e - m_es) / m_per;
            r  = (e - m_es) % m_per;
            ch = m_list[k % m_n];
            v  = (r == int'(ST));
            d  = v && ((k % m_n) == m_n - 1);
        end
        if (e > 0) begin
            check("busy", int'(bus.busy), int'(run));
            check("sel", int'({bus.s1, bus.s0}), ch);
            check("sample_valid", int'(bus.sample_valid), int'(v));
            check("scan_done", int'(bus.scan_done), int'(d));
            if (v) begin
                check("sample_ch", int'(bus.sample_ch), ch);
                check("sample_bit", int'(bus.sample_bit), int'(pattern[ch]));
            end
`ifdef MUX_SCAN_PARITY_EN
            if (d) begin
                par = 0;
                for (int i = 0; i < m_n; i++) par = par ^ int'(pattern[m_list[i]]);
                check("scan_parity", int'(bus.scan_parity), par);
            end
            if (bus.scan_done) last_par = int'(bus.scan_parity);
`endif
            if (bus.sample_valid) begin
                strobes.push_back('{e, int'(bus.sample_ch), int'(bus.sample_bit),
                                   int'(bus.scan_done)});
            end
            if (prev_busy && !bus.busy) busy_fall = e;
        end
        prev_busy = bus.busy;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge; returns the edge number that sampled it.
    task automatic pulse_start(output int es);
        bus.start = 1'b1;
        step(1);
        es = edge_n;
        bus.start = 1'b0;
    endtask

    initial begin : stim
        int es;
        int exp_ch [4];
        int exp_b [4];
        bus.start      = 1'b0;
        bus.stop       = 1'b0;
        bus.continuous = 1'b0;
        bus.ch_mask    = 4'd0;
        bus.dwell      = '0;
        step(2);
        rst = 1'b0;
        check("rst_busy", int'(bus.busy), 0);
        check("rst_sel", int'({bus.s1, bus.s0}), 0);
        check("rst_sample_ch", int'(bus.sample_ch), 0);
        check("rst_sample_bit", int'(bus.sample_bit), 0);

        // Single pass over all four channels, bits 1,0,1,1.
        pattern     = 4'b1101;
        bus.ch_mask = 4'hF;
        strobes.delete();
        pulse_start(es);
        step(15);
        exp_b = '{1, 0, 1, 1};
        check("p1_count", strobes.size(), 4);
        for (int i = 0; i < 4 && i < strobes.size(); i++) begin
            check("p1_edge", strobes[i].e, es + 2 + 3 * i);
            check("p1_ch", strobes[i].ch, i);
            check("p1_bit", strobes[i].b, exp_b[i]);
            check("p1_done", strobes[i].d, (i == 3) ? 1 : 0);
        end
        check("p1_busy_fall", busy_fall, es + 12);

        // Start with an empty mask is ignored.
        bus.ch_mask = 4'd0;
        pulse_start(es);
        step(3);
        check("mask0_busy", int'(bus.busy), 0);

        // Mid-scan start pulse and mask change leave the scan alone.
        pattern     = 4'b0110;
        bus.ch_mask = 4'hF;
        strobes.delete();
        pulse_start(es);
        step(4);
        bus.ch_mask = 4'b0001;
        bus.start   = 1'b1;
        step(1);
        bus.start = 1'b0;
        step(12);
        check("ign_count", strobes.size(), 4);
        for (int i = 0; i < 4 && i < strobes.size(); i++) check("ign_ch", strobes[i].ch, i);
        check("ign_busy", int'(bus.busy), 0);

        // Sparse continuous scan: channels 1,3 with dwell 5, period 8.
        pattern        = 4'b1010;
        bus.ch_mask    = 4'b1010;
        bus.continuous = 1'b1;
        bus.dwell      = 4'd5;
        strobes.delete();
        pulse_start(es);
        step(35);
        exp_ch = '{1, 3, 1, 3};
        check("cont_count", strobes.size(), 5);
        for (int i = 0; i < 4 && i < strobes.size(); i++) begin
            check("cont_edge", strobes[i].e, es + 2 + 8 * i);
            check("cont_ch", strobes[i].ch, exp_ch[i]);
            check("cont_done", strobes[i].d, (i % 2 == 1) ? 1 : 0);
        end
        bus.stop = 1'b1;
        step(1);
        bus.stop = 1'b0;
        check("cont_stop_busy", int'(bus.busy), 0);

        // Single enabled channel: every sample closes a pass.
        bus.ch_mask = 4'b0100;
        bus.dwell   = 4'd1;
        pulse_start(es);
        step(16);
        bus.stop = 1'b1;
        step(1);
        bus.stop       = 1'b0;
        bus.continuous = 1'b0;

        // Abort during SETTLE of channel 2; stop meets the capture edge.
        pattern     = 4'b1111;
        bus.ch_mask = 4'hF;
        bus.dwell   = '0;
        strobes.delete();
        pulse_start(es);
        step(7);
        bus.stop = 1'b1;
        step(1);
        bus.stop = 1'b0;
        check("abort_busy", int'(bus.busy), 0);
        check("abort_sel", int'({bus.s1, bus.s0}), 0);
        step(5);
        check("abort_count", strobes.size(), 2);
        for (int i = 0; i < strobes.size(); i++) check("abort_done", strobes[i].d, 0);

        // Reset held for two cycles mid-scan.
        pulse_start(es);
        step(4);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        check("mrst_busy", int'(bus.busy), 0);
        check("mrst_sel", int'({bus.s1, bus.s0}), 0);
        check("mrst_valid", int'(bus.sample_valid), 0);
        check("mrst_done", int'(bus.scan_done), 0);

`ifdef MUX_SCAN_PARITY_EN
        // Bits 1,1,0,1 give odd parity.
        pattern = 4'b1011;
        pulse_start(es);
        step(15);
        check("parity_lit", last_par, 1);
`endif

        step(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
